// File: rtl/parity_seq_ctrl.sv
// Serial parity generator: accepts a word, folds its bits LSB-first into a parity accumulator,
// then presents the word with its parity bit. Define PARITY_ODD_EN for odd parity (default even).
module parity_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] SHIFT = 3'b010;
  localparam logic [2:0] DONE  = 3'b100;

`ifdef PARITY_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  logic [2:0]        state_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] shift_r;
  logic              acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              parity_r;
  logic [7:0]        frame_cnt_r;

  // One-hot state bits drive the handshake flags directly, so they come straight from flops.
  assign in_ready   = state_r[0];
  assign busy       = ~state_r[0];
  assign out_valid  = state_r[2];
  assign out_data   = data_r;
  assign out_parity = parity_r;
  assign frame_cnt  = frame_cnt_r;

  // Control FSM with serial parity datapath and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      data_r      <= '0;
      shift_r     <= '0;
      acc_r       <= 1'b0;
      cnt_r       <= '0;
      parity_r    <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            shift_r <= in_data;
            acc_r   <= 1'b0;
            cnt_r   <= '0;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // All DATA_W bits are folded in before the transition cycle, giving DATA_W+1 latency.
          if (cnt_r == LAST_CNT) begin
            parity_r <= acc_r ^ PAR_INV;
            state_r  <= DONE;
          end else begin
            acc_r   <= acc_r ^ shift_r[0];
            shift_r <= shift_r >> 1;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Randomized self-checking bench for parity_seq_ctrl (DATA_W=8); the parity model follows
// PARITY_ODD_EN so the same bench covers both builds.
module tb_parity_seq_ctrl;

  localparam int DATA_W = 8;
`ifdef PARITY_ODD_EN
  localparam int ODD = 1;
`else
  localparam int ODD = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_parity;
  logic              busy;
  logic [7:0]        frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;

  parity_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: parity bit makes the number of ones even (or odd in the odd build).
  function automatic int exp_par(input logic [DATA_W-1:0] w);
    return ($countones(w) + ODD) % 2;
  endfunction

  function automatic int exp_cnt();
    return exp_frames % 256;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_par"}, out_parity, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
  endtask

  // One word through the block, with 'stall' cycles of downstream backpressure.
  task automatic xfer(input logic [DATA_W-1:0] w, input int stall);
    int lat;
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    check("shift_ready", in_ready, 0);
    check("shift_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DATA_W'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, DATA_W + 1);
    check("out_data", out_data, w);
    check("out_parity", out_parity, exp_par(w));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, w);
      check("hold_par", out_parity, exp_par(w));
      check("hold_ready", in_ready, 0);
      check("hold_cnt", frame_cnt, exp_cnt());
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames++;
    check("frame_cnt", frame_cnt, exp_cnt());
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
  endtask

  // in_valid and out_ready held high: next word starts one cycle after each handshake.
  task automatic run_b2b(input int n);
    int t, last_acc, ov_t, guard;
    logic [DATA_W-1:0] w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = DATA_W'($urandom);
    t = 0;
    last_acc = -1;
    ov_t = 0;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (!in_ready && guard < 40) begin
        @(negedge clk);
        t++;
        guard++;
      end
      check("b2b_ready", in_ready, 1);
      check("b2b_cnt", frame_cnt, exp_cnt());
      if (last_acc >= 0) begin
        check("b2b_gap", t - last_acc, DATA_W + 3);
        check("b2b_after_hs", t - ov_t, 1);
      end
      last_acc = t;
      w = in_data;
      @(negedge clk);
      t++;
      in_data = DATA_W'($urandom);
      guard = 0;
      while (!out_valid && guard < 40) begin
        @(negedge clk);
        t++;
        guard++;
      end
      check("b2b_lat", t - last_acc - 1, DATA_W + 1);
      check("b2b_data", out_data, w);
      check("b2b_par", out_parity, exp_par(w));
      ov_t = t;
      exp_frames++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_final_cnt", frame_cnt, exp_cnt());
    check("b2b_final_ready", in_ready, 1);
  endtask

  initial begin
    logic [DATA_W-1:0] dir_words [4];
    dir_words[0] = 8'h00;
    dir_words[1] = 8'h01;
    dir_words[2] = 8'hFF;
    dir_words[3] = 8'hA7;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #1;
    check_reset_state("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (dir_words[i]) xfer(dir_words[i], 0);

    xfer(8'h5A, 20);

    // Reset in the middle of SHIFT discards the word.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    check("rel_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rel_no_valid", out_valid, 0);
      check("rel_cnt", frame_cnt, 0);
    end

    for (int i = 0; i < 30; i++) xfer(DATA_W'($urandom), int'($urandom_range(0, 3)));

    run_b2b(6);

    // Counter wrap from a known zero.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    for (int i = 0; i < 255; i++) xfer(DATA_W'($urandom), 0);
    check("wrap255", frame_cnt, 255);
    xfer(DATA_W'($urandom), 0);
    check("wrap0", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
